// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the single VGA adapter pixel write port
// among the three drawing engines (background, car eraser, car drawer).
// A grant lasts for a whole burst and ends on done, on request withdrawal,
// or when a watchdog sees the holder stop plotting for too long.
module vga_write_arbiter #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       req,
  input  logic [2:0]       done,
  input  logic [2:0]       plot_in,
  input  logic [3*X_W-1:0] x_in,
  input  logic [3*Y_W-1:0] y_in,
  input  logic [3*C_W-1:0] col_in,
  output logic [2:0]       grant,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [C_W-1:0]   vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       timeout_id
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  // The counter holds the number of idle cycles before the current one, so a
  // holder that is also idle now has been idle for TIMEOUT-1 cycles when the
  // counter equals TIMEOUT-2.
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       grant_reg, grant_next;
  logic [1:0]       last_winner_reg, last_winner_next;
  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic [X_W-1:0]   vga_x_reg, vga_x_next;
  logic [Y_W-1:0]   vga_y_reg, vga_y_next;
  logic [C_W-1:0]   vga_colour_reg, vga_colour_next;
  logic             vga_plot_reg, vga_plot_next;
  logic             timeout_err_reg, timeout_err_next;
  logic [1:0]       timeout_id_reg, timeout_id_next;

  // Unpacked per-requester views of the packed coordinate buses
  logic [X_W-1:0] x_arr [3];
  logic [Y_W-1:0] y_arr [3];
  logic [C_W-1:0] c_arr [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
      assign x_arr[gi] = x_in[gi*X_W +: X_W];
      assign y_arr[gi] = y_in[gi*Y_W +: Y_W];
      assign c_arr[gi] = col_in[gi*C_W +: C_W];
    end
  endgenerate

  logic [1:0] holder_idx;
  logic       h_plot, h_done, h_req;

  // Encode the one-hot grant into the holder index and pick its strobes
  always_comb begin
    holder_idx = 2'd0;
    if (grant_reg[1]) holder_idx = 2'd1;
    if (grant_reg[2]) holder_idx = 2'd2;
    h_plot = plot_in[holder_idx];
    h_done = done[holder_idx];
    h_req  = req[holder_idx];
  end

  logic       pick_valid;
  logic [1:0] pick_idx;

  // Round-robin pick: first requester scanning last_winner+1, +2, +3 (mod 3)
  always_comb begin
    logic [2:0] sum;
    logic [1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    sum        = 3'd0;
    cand       = 2'd0;
    // Walk from the farthest offset down so the nearest offset wins
    for (int k = 3; k >= 1; k--) begin
      sum  = {1'b0, last_winner_reg} + 3'(k);
      cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state, grant, watchdog and pixel path
  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    last_winner_next = last_winner_reg;
    wd_cnt_next      = wd_cnt_reg;
    vga_x_next       = vga_x_reg;
    vga_y_next       = vga_y_reg;
    vga_colour_next  = vga_colour_reg;
    vga_plot_next    = 1'b0;
    timeout_err_next = 1'b0;
    timeout_id_next  = timeout_id_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next       = 3'b001 << pick_idx;
          last_winner_next = pick_idx;
          wd_cnt_next      = '0;
          state_next       = GRANT;
        end
      end
      GRANT: begin
        vga_plot_next = h_plot;
        if (h_plot) begin
          vga_x_next      = x_arr[holder_idx];
          vga_y_next      = y_arr[holder_idx];
          vga_colour_next = c_arr[holder_idx];
          wd_cnt_next     = '0;
        end else if (wd_cnt_reg != CNT_MAX) begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
        // A plot, done or withdrawal on the limit cycle wins over the watchdog
        if (h_done || !h_req) begin
          grant_next = 3'b000;
          state_next = RELEASE;
        end else if (!h_plot && (wd_cnt_reg == CNT_LIMIT)) begin
          grant_next       = 3'b000;
          state_next       = RELEASE;
          timeout_err_next = 1'b1;
          timeout_id_next  = holder_idx;
        end
      end
      RELEASE: begin
        grant_next = 3'b000;
        state_next = IDLE;
      end
      default: begin
        grant_next = 3'b000;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset also drops any pixel in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      grant_reg       <= 3'b000;
      last_winner_reg <= 2'd2;
      wd_cnt_reg      <= '0;
      vga_x_reg       <= '0;
      vga_y_reg       <= '0;
      vga_colour_reg  <= '0;
      vga_plot_reg    <= 1'b0;
      timeout_err_reg <= 1'b0;
      timeout_id_reg  <= 2'd0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      last_winner_reg <= last_winner_next;
      wd_cnt_reg      <= wd_cnt_next;
      vga_x_reg       <= vga_x_next;
      vga_y_reg       <= vga_y_next;
      vga_colour_reg  <= vga_colour_next;
      vga_plot_reg    <= vga_plot_next;
      timeout_err_reg <= timeout_err_next;
      timeout_id_reg  <= timeout_id_next;
    end
  end

  assign grant       = grant_reg;
  assign vga_x       = vga_x_reg;
  assign vga_y       = vga_y_reg;
  assign vga_colour  = vga_colour_reg;
  assign vga_plot    = vga_plot_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_err_reg;
  assign timeout_id  = timeout_id_reg;

endmodule
